// File: rtl/scmp_pkg.sv
// rtl/scmp_pkg.sv - shared flag type and reset seed for the scmp comparator slice
package scmp_pkg;

   typedef struct packed {
      logic ab;
      logic eq;
      logic ba;
   } scmp_flags_t;

   // Equal-so-far seed, identical to the value tied into slice 0 of a chain
   localparam scmp_flags_t SCMP_FLAGS_RST = '{ab: 1'b0, eq: 1'b1, ba: 1'b0};

endpackage

// File: rtl/scmp_sat_cnt.sv
// rtl/scmp_sat_cnt.sv - CNT_W-bit saturating event counter with synchronous clear
module scmp_sat_cnt #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      // Stick at all-ones so a long run never wraps back to a small count
      if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/scmp.sv
// rtl/scmp.sv - ripple-chain equality/magnitude comparator slice with registered flags
// Optional statistics counters are built when SCMP_STATS_EN is defined.
module scmp
   import scmp_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             eqi_i,
   output logic             ab_o,
   output logic             eq_o,
   output logic             ba_o,
   output logic             ab_q_o,
   output logic             eq_q_o,
   output logic             ba_q_o
`ifdef SCMP_STATS_EN
   ,
   output logic [CNT_W-1:0] eq_cnt_o,
   output logic [CNT_W-1:0] ab_cnt_o,
   output logic [CNT_W-1:0] ba_cnt_o
`endif
);

   scmp_flags_t flags_d;
   scmp_flags_t flags_q;

   // ab/ba give a local verdict only; eqi merely gates the equality ripple
   always_comb begin
      flags_d    = SCMP_FLAGS_RST;
      flags_d.ab = (a_i > b_i);
      flags_d.ba = (a_i < b_i);
      flags_d.eq = eqi_i & (a_i == b_i);
   end

   assign ab_o = flags_d.ab;
   assign eq_o = flags_d.eq;
   assign ba_o = flags_d.ba;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flags_q <= SCMP_FLAGS_RST;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign ab_q_o = flags_q.ab;
   assign eq_q_o = flags_q.eq;
   assign ba_q_o = flags_q.ba;

`ifdef SCMP_STATS_EN
   scmp_sat_cnt #(.CNT_W(CNT_W)) u_eq_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (flags_d.eq),
      .cnt_o (eq_cnt_o)
   );

   scmp_sat_cnt #(.CNT_W(CNT_W)) u_ab_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (flags_d.ab),
      .cnt_o (ab_cnt_o)
   );

   scmp_sat_cnt #(.CNT_W(CNT_W)) u_ba_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (flags_d.ba),
      .cnt_o (ba_cnt_o)
   );
`else
   // Counter width is meaningless without the statistics build; only sanity-guarded here
   if (CNT_W < 1) begin : g_cnt_w_illegal
   end
`endif

endmodule

// File: tb/tb_scmp.sv
// tb/tb_scmp.sv - self-checking bench for scmp (single slices, 32x1 chain, SCMP_STATS_EN counters)
module tb_scmp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Single 1-bit slice, small counters to reach saturation quickly
   logic a1, b1, eqi1;
   logic ab1, eq1, ba1, abq1, eqq1, baq1;
`ifdef SCMP_STATS_EN
   logic [1:0] eqc1, abc1, bac1;
`endif

   scmp #(.WIDTH(1), .CNT_W(2)) dut1 (
      .clk_i(clk), .rst_i(rst), .a_i(a1), .b_i(b1), .eqi_i(eqi1),
      .ab_o(ab1), .eq_o(eq1), .ba_o(ba1),
      .ab_q_o(abq1), .eq_q_o(eqq1), .ba_q_o(baq1)
`ifdef SCMP_STATS_EN
      , .eq_cnt_o(eqc1), .ab_cnt_o(abc1), .ba_cnt_o(bac1)
`endif
   );

   // 8-bit slice for randomized magnitude checks
   logic [7:0] a8, b8;
   logic eqi8;
   logic ab8, eq8, ba8, abq8, eqq8, baq8;
`ifdef SCMP_STATS_EN
   logic [15:0] eqc8, abc8, bac8;
`endif

   scmp #(.WIDTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .a_i(a8), .b_i(b8), .eqi_i(eqi8),
      .ab_o(ab8), .eq_o(eq8), .ba_o(ba8),
      .ab_q_o(abq8), .eq_q_o(eqq8), .ba_q_o(baq8)
`ifdef SCMP_STATS_EN
      , .eq_cnt_o(eqc8), .ab_cnt_o(abc8), .ba_cnt_o(bac8)
`endif
   );

   // 32 x 1-bit ripple chain, LSB slice seeded with eqi=1
   logic [31:0] ca, cb;
   logic [32:0] ceq;
   logic [31:0] cab, cba, cabq, ceqq, cbaq;
`ifdef SCMP_STATS_EN
   logic [15:0] c_eqc [32];
   logic [15:0] c_abc [32];
   logic [15:0] c_bac [32];
`endif
   assign ceq[0] = 1'b1;

   for (genvar g = 0; g < 32; g++) begin : g_chain
      scmp #(.WIDTH(1)) u_slice (
         .clk_i(clk), .rst_i(rst), .a_i(ca[g]), .b_i(cb[g]), .eqi_i(ceq[g]),
         .ab_o(cab[g]), .eq_o(ceq[g+1]), .ba_o(cba[g]),
         .ab_q_o(cabq[g]), .eq_q_o(ceqq[g]), .ba_q_o(cbaq[g])
`ifdef SCMP_STATS_EN
         , .eq_cnt_o(c_eqc[g]), .ab_cnt_o(c_abc[g]), .ba_cnt_o(c_bac[g])
`endif
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: word-level compare of the whole chain; slice verdict comes from the top bit only
   task automatic chain_check(input string tag, input logic [31:0] A, input logic [31:0] B);
      @(negedge clk);
      ca = A;
      cb = B;
      #1;
      chk({tag, "_eq"}, ceq[32], (A == B));
      chk({tag, "_ab"}, cab[31], (A[31] == 1'b1 && B[31] == 1'b0));
      chk({tag, "_ba"}, cba[31], (A[31] == 1'b0 && B[31] == 1'b1));
   endtask

   initial begin
      logic [2:0] v;
      logic       exp_ab, exp_eq, exp_ba;
      int         ea, eb;
      logic [31:0] ra, rb;

      a1 = 0; b1 = 0; eqi1 = 1;
      a8 = 0; b8 = 0; eqi8 = 1;
      ca = 0; cb = 0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_abq", abq1, 1'b0);
      chk("rst_eqq", eqq1, 1'b1);
      chk("rst_baq", baq1, 1'b0);
`ifdef SCMP_STATS_EN
      chk("rst_eqcnt", eqc1, 2'd0);
`endif
      rst = 1'b0;

      // Exhaustive 1-bit truth table, comb then one-cycle-late registered copy
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         a1 = v[2]; b1 = v[1]; eqi1 = v[0];
         exp_ab = (a1 == 1'b1) && (b1 == 1'b0);
         exp_ba = (a1 == 1'b0) && (b1 == 1'b1);
         exp_eq = (eqi1 == 1'b1) && (a1 == b1);
         #1;
         chk($sformatf("tt%0d_ab", i), ab1, exp_ab);
         chk($sformatf("tt%0d_eq", i), eq1, exp_eq);
         chk($sformatf("tt%0d_ba", i), ba1, exp_ba);
         @(negedge clk);
         chk($sformatf("tt%0d_abq", i), abq1, exp_ab);
         chk($sformatf("tt%0d_eqq", i), eqq1, exp_eq);
         chk($sformatf("tt%0d_baq", i), baq1, exp_ba);
      end

      // Directed chain cases
      chain_check("ch_deadbeef", 32'hDEADBEEF, 32'hDEADBEEF);
      chain_check("ch_lt",       32'h7FFFFFFF, 32'h80000000);
      chain_check("ch_gt",       32'h80000000, 32'h7FFFFFFF);
      chain_check("ch_noverd",   32'h00000001, 32'h00000000);

      // Randomized chain words, every fourth one forced equal
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = (i % 4 == 0) ? ra : $urandom;
         if (i % 4 == 1) rb = ra ^ (32'h1 << $urandom_range(0, 31));
         chain_check($sformatf("ch_rnd%0d", i), ra, rb);
      end

      // Randomized 8-bit slice against integer magnitude compare
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         a8 = 8'($urandom);
         b8 = (i % 5 == 0) ? a8 : 8'($urandom);
         eqi8 = 1'($urandom);
         ea = int'(a8);
         eb = int'(b8);
         exp_ab = ea > eb;
         exp_ba = ea < eb;
         exp_eq = eqi8 && (ea == eb);
         #1;
         chk($sformatf("w8_%0d_ab", i), ab8, exp_ab);
         chk($sformatf("w8_%0d_eq", i), eq8, exp_eq);
         chk($sformatf("w8_%0d_ba", i), ba8, exp_ba);
         @(negedge clk);
         chk($sformatf("w8_%0d_q", i), {abq8, eqq8, baq8}, {exp_ab, exp_eq, exp_ba});
      end

      // Mid-run reset wins over an active ab, then ab_q follows one cycle later
      @(negedge clk);
      a1 = 1; b1 = 0; eqi1 = 1;
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_abq", abq1, 1'b0);
      chk("mrst_eqq", eqq1, 1'b1);
      chk("mrst_baq", baq1, 1'b0);
`ifdef SCMP_STATS_EN
      chk("mrst_abcnt", abc1, 2'd0);
      chk("mrst_eqcnt", eqc1, 2'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("post_abq", abq1, 1'b1);
      chk("post_eqq", eqq1, 1'b0);

`ifdef SCMP_STATS_EN
      // Saturation with CNT_W=2: eq held high for 5 edges
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a1 = 1; b1 = 1; eqi1 = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("sat%0d_eqcnt", i), eqc1, (i < 3) ? 32'(i + 1) : 32'd3);
         chk($sformatf("sat%0d_abcnt", i), abc1, 2'd0);
         chk($sformatf("sat%0d_bacnt", i), bac1, 2'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
